// File: rtl/group_serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// group_serial_subtractor_pkg
// Shared definitions for the group-serial subtractor:
//   - default operand / group widths (taken from the INPUTSIZE / GROUPSIZE
//     macros when the build defines them, otherwise 32 / 4)
//   - FSM state encoding
//   - helpers for the group count and the group-counter width
// ---------------------------------------------------------------------------
`ifndef INPUTSIZE
`define INPUTSIZE 32
`endif
`ifndef GROUPSIZE
`define GROUPSIZE 4
`endif

package group_serial_subtractor_pkg;

    localparam int INPUTSIZE_DEF = `INPUTSIZE;
    localparam int GROUPSIZE_DEF = `GROUPSIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_e;

    // Number of groups; a zero group size yields 1 so that elaboration can
    // reach the parameter check instead of dividing by zero.
    function automatic int num_groups(input int insz, input int gsz);
        return (gsz > 0) ? (insz / gsz) : 1;
    endfunction

    // Group counter width, never narrower than one bit.
    function automatic int grp_cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int NUM_GROUPS_DEF = num_groups(INPUTSIZE_DEF, GROUPSIZE_DEF);
    localparam int GRP_CNT_W_DEF  = grp_cnt_width(NUM_GROUPS_DEF);

endpackage

// File: rtl/group_serial_subtractor_cell.sv
// ---------------------------------------------------------------------------
// group_subtract_cell
// Combinational GROUPSIZE-bit slice computing a + ~b + cin. Subtraction
// with a borrow is done as addition of the inverted subtrahend with an
// inverted borrow as carry-in; the caller inverts cout back into a borrow.
// Ports:
//   a_i    [GROUPSIZE-1:0]  minuend group
//   b_i    [GROUPSIZE-1:0]  subtrahend group
//   cin_i                   carry-in (= ~borrow)
//   diff_o [GROUPSIZE-1:0]  group difference
//   cout_o                  carry-out (= ~borrow-out)
// ---------------------------------------------------------------------------
module group_subtract_cell #(
    parameter int GROUPSIZE = 4
) (
    input  logic [GROUPSIZE-1:0] a_i,
    input  logic [GROUPSIZE-1:0] b_i,
    input  logic                 cin_i,
    output logic [GROUPSIZE-1:0] diff_o,
    output logic                 cout_o
);

    logic [GROUPSIZE:0] sum;

    assign sum    = {1'b0, a_i} + {1'b0, ~b_i} + (GROUPSIZE+1)'(cin_i);
    assign diff_o = sum[GROUPSIZE-1:0];
    assign cout_o = sum[GROUPSIZE];

endmodule

// File: rtl/group_serial_subtractor.sv
// ---------------------------------------------------------------------------
// group_serial_subtractor
// Computes D = A - B - b0 one GROUPSIZE-bit group per cycle (LSB first)
// through a single shared subtract cell and a registered borrow, then
// derives sign and magnitude of the two's-complement result.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        operand handshake
//   A, B [INPUTSIZE-1:0]       unsigned minuend / subtrahend
//   b0                         borrow-in
//   out_valid / out_ready      result handshake
//   D   [INPUTSIZE:0]          two's-complement difference, bit INPUTSIZE = sign
//   NEG                        result is negative
//   MAG [INPUTSIZE:0]          magnitude of D
// ---------------------------------------------------------------------------
module group_serial_subtractor
    import group_serial_subtractor_pkg::*;
#(
    parameter int INPUTSIZE = INPUTSIZE_DEF,
    parameter int GROUPSIZE = GROUPSIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INPUTSIZE-1:0] A,
    input  logic [INPUTSIZE-1:0] B,
    input  logic                 b0,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INPUTSIZE:0]   D,
    output logic                 NEG,
    output logic [INPUTSIZE:0]   MAG
);

    localparam int NUM_GROUPS = num_groups(INPUTSIZE, GROUPSIZE);
    localparam int CNT_W      = grp_cnt_width(NUM_GROUPS);
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GROUPS - 1);

    generate
        if ((GROUPSIZE < 1) || ((INPUTSIZE % ((GROUPSIZE < 1) ? 1 : GROUPSIZE)) != 0)) begin : g_param_check
            $error("group_serial_subtractor: GROUPSIZE must be >= 1 and divide INPUTSIZE");
        end
    endgenerate

    state_e               state_q;
    logic [INPUTSIZE-1:0] a_q, b_q;
    logic                 borrow_q;
    logic [CNT_W-1:0]     grp_q;
    logic [INPUTSIZE:0]   d_q, mag_q;
    logic                 neg_q, in_ready_q, out_valid_q;

    // Group select: shift the current group down to bit 0.
    logic [31:0]          grp_shift;
    logic [INPUTSIZE-1:0] a_shifted, b_shifted;
    logic [GROUPSIZE-1:0] a_grp, b_grp, diff;
    logic                 cout;

    assign grp_shift = 32'(grp_q) * 32'(GROUPSIZE);
    assign a_shifted = a_q >> grp_shift;
    assign b_shifted = b_q >> grp_shift;
    assign a_grp     = a_shifted[GROUPSIZE-1:0];
    assign b_grp     = b_shifted[GROUPSIZE-1:0];

    group_subtract_cell #(
        .GROUPSIZE (GROUPSIZE)
    ) u_cell (
        .a_i    (a_grp),
        .b_i    (b_grp),
        .cin_i  (~borrow_q),
        .diff_o (diff),
        .cout_o (cout)
    );

    // Next value of the low difference bits: replace only the current group.
    logic [INPUTSIZE-1:0] grp_mask, d_lo_d;

    assign grp_mask = INPUTSIZE'({GROUPSIZE{1'b1}}) << grp_shift;
    assign d_lo_d   = (d_q[INPUTSIZE-1:0] & ~grp_mask) | (INPUTSIZE'(diff) << grp_shift);

    // Sign-magnitude conversion of the completed difference.
    logic [INPUTSIZE:0] d_full, mag_d;

    assign d_full = {borrow_q, d_q[INPUTSIZE-1:0]};
    assign mag_d  = borrow_q ? (~d_full + 1'b1) : d_full;

    // NOTE: all state, including the datapath registers, is updated with
    // non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so an aborted operation
            // leaves D/NEG/MAG at zero rather than at a stale result.
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            grp_q       <= '0;
            d_q         <= '0;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= A;
                        b_q        <= B;
                        borrow_q   <= b0;
                        grp_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SUB;
                    end
                end
                SUB: begin
                    d_q[INPUTSIZE-1:0] <= d_lo_d;
                    borrow_q           <= ~cout;
                    if (grp_q == LAST_GRP) begin
                        state_q <= CONV;
                    end else begin
                        grp_q <= grp_q + 1'b1;
                    end
                end
                CONV: begin
                    d_q[INPUTSIZE] <= borrow_q;
                    neg_q          <= borrow_q;
                    mag_q          <= mag_d;
                    out_valid_q    <= 1'b1;
                    state_q        <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign NEG       = neg_q;
    assign MAG       = mag_q;

endmodule

// File: tb/tb_group_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_group_serial_subtractor
// Directed and randomised checks of group_serial_subtractor at default
// widths (INPUTSIZE=32, GROUPSIZE=4).
// ---------------------------------------------------------------------------
module tb_group_serial_subtractor;

    localparam int W  = 32;
    localparam int G  = 4;
    localparam int NG = W / G;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         b0 = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   D, MAG;
    logic         NEG;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    group_serial_subtractor #(
        .INPUTSIZE (W),
        .GROUPSIZE (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .b0        (b0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .NEG       (NEG),
        .MAG       (MAG)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: wait for in_ready, accept, scramble the operand
    // inputs while busy, measure latency, check result, stall, hand off.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bb, input int stall);
        logic [W:0] exp_d, exp_mag;
        logic       exp_neg;
        int         waited;
        int         edges;

        exp_d   = {1'b0, a} - {1'b0, b} - (W+1)'(bb);
        exp_neg = exp_d[W];
        exp_mag = exp_neg ? ((W+1)'(0) - exp_d) : exp_d;

        waited = 0;
        while (!in_ready && waited < 40) begin
            step();
            waited++;
        end
        if (!in_ready) check({tag, " in_ready timeout"}, 64'(in_ready), 64'd1);

        in_valid = 1'b1;
        A        = a;
        B        = b;
        b0       = bb;
        step();                     // accept edge
        in_valid = 1'b0;

        edges = 0;
        while (!out_valid && edges < 40) begin
            A  = $urandom;          // must not affect the running operation
            B  = $urandom;
            b0 = 1'($urandom);
            step();
            edges++;
        end
        // NUM_GROUPS SUB edges plus one CONV edge (10 cycles counting the accept cycle).
        check({tag, " latency"}, 64'(edges), 64'(NG + 1));
        check({tag, " D"},   64'(D),   64'(exp_d));
        check({tag, " NEG"}, 64'(NEG), 64'(exp_neg));
        check({tag, " MAG"}, 64'(MAG), 64'(exp_mag));

        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            step();
            check({tag, " stall out_valid"}, 64'(out_valid), 64'd1);
            check({tag, " stall in_ready"},  64'(in_ready),  64'd0);
            check({tag, " stall D"},         64'(D),         64'(exp_d));
            check({tag, " stall MAG"},       64'(MAG),       64'(exp_mag));
        end

        out_ready = 1'b1;
        check({tag, " in_ready before handshake"}, 64'(in_ready), 64'd0);
        step();                     // handshake edge
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready after handshake"},  64'(in_ready),  64'd1);
    endtask

    initial begin
        int seen_valid;

        // Reset state
        #12;
        check("reset in_ready",  64'(in_ready),  64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset D",         64'(D),         64'd0);
        check("reset NEG",       64'(NEG),       64'd0);
        check("reset MAG",       64'(MAG),       64'd0);
        rst_n = 1'b1;
        step();

        // Directed vectors
        run_op("5-4",      32'd5, 32'd4, 1'b0, 0);
        run_op("4-5",      32'd4, 32'd5, 1'b0, 0);
        run_op("0-max-1",  32'd0, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("equal",    32'h1234_5678, 32'h1234_5678, 1'b0, 5);
        run_op("max-0",    32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        run_op("0-0-1",    32'd0, 32'd0, 1'b1, 0);

        // Block stays idle and ready between operations
        check("idle in_ready", 64'(in_ready), 64'd1);

        // Reset mid-operation: accept 100-1, drop reset during SUB cycle 3
        step();
        in_valid = 1'b1;
        A        = 32'd100;
        B        = 32'd1;
        b0       = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort in_ready",  64'(in_ready),  64'd1);
        check("abort D",         64'(D),         64'd0);
        check("abort MAG",       64'(MAG),       64'd0);
        step();
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) seen_valid++;
        end
        check("abort no result", 64'(seen_valid), 64'd0);
        check("abort idle in_ready", 64'(in_ready), 64'd1);

        // Randomised operands with random result stalls
        for (int n = 0; n < 1000; n++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
